// File: rtl/post_slow_sched.sv
// Boot supervisor that follows CPU POST activity. It asks the I2C injector to
// slow the CPU down early in POST and to speed it back up later. A stalled POST
// or an unexpected CPU reset produces an open-drain reset pulse and another
// attempt. After too many failed attempts the block stops retrying.
module post_slow_sched #(
    parameter logic [7:0]  SLOW_AT       = 8'd1,
    parameter logic [7:0]  FAST_AT       = 8'd4,
    parameter logic [7:0]  DONE_AT       = 8'd12,
    parameter logic [19:0] TIMEOUT_TICKS = 20'd400000,
    parameter logic [19:0] RST_TICKS     = 20'd40000,
    parameter logic [3:0]  MAX_TRIES     = 4'd15
) (
    input  logic       clk_400k,
    input  logic       rst,
    input  logic       enable,
    input  logic       post_bit,
    input  logic       cpu_rst_n,
    output logic       i2c_send,
    output logic       cpu_rst_drive,
    output logic [3:0] tries,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_SLOW   = 3'd2,
        ST_FAST   = 3'd3,
        ST_DONE   = 3'd4,
        ST_RSTOUT = 3'd5,
        ST_FAIL   = 3'd6
    } state_t;

    // Minimum spacing between two changes of i2c_send, minus one. The counter
    // is loaded on a change and a new change is allowed once it reads zero.
    localparam logic [7:0] HOLDOFF_LOAD = 8'hFF;

    // Synchronizer chains. Bit 0 is the first flop. In the POST chain, bit 2 is
    // the extra flop that holds the previous synchronized value for edge detection.
    logic [2:0] postSync_q;
    logic [1:0] rstnSync_q;

    state_t     state_q,      state_d;
    logic [7:0] postCnt_q,    postCnt_d;
    logic [19:0] idleCnt_q,   idleCnt_d;
    logic [3:0] tries_q,      tries_d;
    logic       i2cSend_q,    i2cSend_d;
    logic       driveLow_q,   driveLow_d;
    logic [19:0] rstCnt_q,    rstCnt_d;
    logic [7:0] holdoff_q,    holdoff_d;

    logic       postEdge;
    logic       rstnSynced;
    logic [7:0] postCntInc;
    logic [7:0] postCntNext;
    logic [3:0] triesInc;
    logic       idleTimeout;
    logic       holdoffDone;
    logic       pulseEnd;

    // Move both asynchronous CPU signals into the clk_400k domain.
    always_ff @(posedge clk_400k) begin
        if (rst) begin
            postSync_q <= 3'b111;
            rstnSync_q <= 2'b11;
        end else begin
            postSync_q <= {postSync_q[1:0], post_bit};
            rstnSync_q <= {rstnSync_q[0], cpu_rst_n};
        end
    end

    assign postEdge    = postSync_q[1] ^ postSync_q[2];
    assign rstnSynced  = rstnSync_q[1];
    assign postCntInc  = (postCnt_q == 8'hFF) ? postCnt_q : postCnt_q + 8'd1;
    assign postCntNext = postEdge ? postCntInc : postCnt_q;
    assign triesInc    = (tries_q == 4'hF) ? tries_q : tries_q + 4'd1;
    assign idleTimeout = (idleCnt_q == TIMEOUT_TICKS - 20'd1);
    assign holdoffDone = (holdoff_q == 8'd0);
    assign pulseEnd    = (rstCnt_q == RST_TICKS - 20'd1);

    // State register and all bookkeeping counters.
    always_ff @(posedge clk_400k) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            postCnt_q  <= 8'd0;
            idleCnt_q  <= 20'd0;
            tries_q    <= 4'd0;
            i2cSend_q  <= 1'b0;
            driveLow_q <= 1'b0;
            rstCnt_q   <= 20'd0;
            holdoff_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            postCnt_q  <= postCnt_d;
            idleCnt_q  <= idleCnt_d;
            tries_q    <= tries_d;
            i2cSend_q  <= i2cSend_d;
            driveLow_q <= driveLow_d;
            rstCnt_q   <= rstCnt_d;
            holdoff_q  <= holdoff_d;
        end
    end

    // Next-state logic. A CPU reset observed while tracking POST takes priority
    // over both a POST edge and a timeout. A POST edge in the same cycle as the
    // timeout counts as progress. Hangs and disable clear i2c_send immediately.
    // Only the slow-to-fast release waits for the holdoff window.
    always_comb begin
        state_d    = state_q;
        postCnt_d  = postCnt_q;
        idleCnt_d  = idleCnt_q;
        tries_d    = tries_q;
        i2cSend_d  = i2cSend_q;
        driveLow_d = driveLow_q;
        rstCnt_d   = rstCnt_q;
        holdoff_d  = holdoffDone ? 8'd0 : holdoff_q - 8'd1;

        if (!enable) begin
            state_d    = ST_IDLE;
            postCnt_d  = 8'd0;
            idleCnt_d  = 20'd0;
            i2cSend_d  = 1'b0;
            driveLow_d = 1'b0;
            rstCnt_d   = 20'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    postCnt_d  = 8'd0;
                    idleCnt_d  = 20'd0;
                    i2cSend_d  = 1'b0;
                    driveLow_d = 1'b0;
                    if (rstnSynced) begin
                        state_d = ST_ARMED;
                    end
                end

                ST_ARMED, ST_SLOW, ST_FAST: begin
                    if (!rstnSynced || (!postEdge && idleTimeout)) begin
                        i2cSend_d = 1'b0;
                        tries_d   = triesInc;
                        postCnt_d = 8'd0;
                        idleCnt_d = 20'd0;
                        rstCnt_d  = 20'd0;
                        if (triesInc < MAX_TRIES) begin
                            state_d    = ST_RSTOUT;
                            driveLow_d = 1'b1;
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end else begin
                        postCnt_d = postCntNext;
                        idleCnt_d = postEdge ? 20'd0 : idleCnt_q + 20'd1;
                        if (state_q == ST_ARMED) begin
                            if (postCntNext >= SLOW_AT) begin
                                state_d   = ST_SLOW;
                                i2cSend_d = 1'b1;
                                holdoff_d = HOLDOFF_LOAD;
                            end
                        end else if (state_q == ST_SLOW) begin
                            if ((postCntNext >= FAST_AT) && holdoffDone) begin
                                state_d   = ST_FAST;
                                i2cSend_d = 1'b0;
                                holdoff_d = HOLDOFF_LOAD;
                            end
                        end else begin
                            if (postCntNext >= DONE_AT) begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end

                ST_RSTOUT: begin
                    i2cSend_d = 1'b0;
                    if (driveLow_q) begin
                        if (pulseEnd) begin
                            driveLow_d = 1'b0;
                            postCnt_d  = 8'd0;
                            idleCnt_d  = 20'd0;
                            rstCnt_d   = 20'd0;
                        end else begin
                            rstCnt_d = rstCnt_q + 20'd1;
                        end
                    end else if (rstnSynced) begin
                        state_d = ST_ARMED;
                    end
                end

                ST_DONE, ST_FAIL: begin
                    i2cSend_d  = 1'b0;
                    driveLow_d = 1'b0;
                end

                default: begin
                    state_d    = ST_IDLE;
                    i2cSend_d  = 1'b0;
                    driveLow_d = 1'b0;
                end
            endcase
        end
    end

    assign i2c_send      = i2cSend_q;
    assign cpu_rst_drive = driveLow_q ? 1'b0 : 1'bz;
    assign tries         = tries_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_post_slow_sched.sv
// Directed-random bench for post_slow_sched. Timeout and pulse length are
// shortened so that every scenario finishes in a few thousand cycles.
module tb_post_slow_sched;

    localparam int SLOW_AT  = 1;
    localparam int FAST_AT  = 4;
    localparam int DONE_AT  = 12;
    localparam int TIMEOUT  = 300;
    localparam int RSTLEN   = 40;
    localparam int MAXTRIES = 15;
    // A toggle driven mid-cycle becomes visible on the outputs after this many rising edges.
    localparam int EDGE_LAT = 3;
    localparam int HOLDOFF  = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       postBit;
    logic       cpuRstN;
    logic       i2cSend;
    wire        cpuRstDrive;
    logic [3:0] triesO;
    logic [2:0] stateO;

    pullup (cpuRstDrive);

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;
    logic postLevel;
    int t, rise, fall, hang, gap, lowLen, lowSeen, expState;

    post_slow_sched #(
        .SLOW_AT(8'(SLOW_AT)),
        .FAST_AT(8'(FAST_AT)),
        .DONE_AT(8'(DONE_AT)),
        .TIMEOUT_TICKS(20'(TIMEOUT)),
        .RST_TICKS(20'(RSTLEN)),
        .MAX_TRIES(4'(MAXTRIES))
    ) dut (
        .clk_400k(clk),
        .rst(rst),
        .enable(enable),
        .post_bit(postBit),
        .cpu_rst_n(cpuRstN),
        .i2c_send(i2cSend),
        .cpu_rst_drive(cpuRstDrive),
        .tries(triesO),
        .state_o(stateO)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected state after a given number of counted POST edges and cycles since the slow request.
    function automatic int modelState(input int edges, input int sinceSlow);
        if (edges >= DONE_AT && sinceSlow >= HOLDOFF) return 4;
        if (edges >= FAST_AT && sinceSlow >= HOLDOFF) return 3;
        if (edges >= SLOW_AT) return 2;
        return 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic stepTo(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic togglePost();
        postLevel = ~postLevel;
        postBit   = postLevel;
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; cpuRstN = 1'b1;
        postLevel = 1'b1; postBit = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", 32'(stateO), 0);
        checkOutput("reset_i2c", 32'(i2cSend), 0);
        checkOutput("reset_tries", 32'(triesO), 0);
        checkOutput("reset_drive", 32'(cpuRstDrive), 1);
        enable = 1'b1;
        @(negedge clk);
        checkOutput("armed_after_enable", 32'(stateO), 1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; postBit = 1'b1; cpuRstN = 1'b1; postLevel = 1'b1;

        // Full boot: twelve edges spaced well beyond the holdoff window.
        applyStimulus();
        t = cyc; togglePost(); rise = t + EDGE_LAT;
        stepTo(t + EDGE_LAT - 1);
        checkOutput("slow_not_early", 32'(i2cSend), 0);
        stepTo(t + EDGE_LAT + 1);
        checkOutput("slow_i2c", 32'(i2cSend), 1);
        checkOutput("slow_state", 32'(stateO), 2);
        for (int n = 2; n <= DONE_AT; n++) begin
            gap = $urandom_range(290, 260);
            stepTo(t + gap);
            t = cyc; togglePost();
            stepTo(t + EDGE_LAT - 1);
            checkOutput("boot_before_edge", 32'(stateO), 32'(modelState(n - 1, cyc - rise)));
            stepTo(t + EDGE_LAT);
            expState = modelState(n, cyc - rise);
            checkOutput("boot_after_edge", 32'(stateO), 32'(expState));
            checkOutput("boot_i2c", 32'(i2cSend), (expState == 2) ? 1 : 0);
        end
        checkOutput("done_tries", 32'(triesO), 0);
        stepTo(cyc + TIMEOUT + 100);
        checkOutput("done_sticky", 32'(stateO), 4);
        checkOutput("done_drive", 32'(cpuRstDrive), 1);

        // Early edges after the slow request: speedup deferred to the holdoff boundary.
        applyStimulus();
        t = cyc; togglePost(); rise = t + EDGE_LAT;
        stepTo(rise + $urandom_range(60, 30));
        for (int n = 2; n <= FAST_AT; n++) begin
            t = cyc; togglePost();
            stepTo(t + $urandom_range(30, 5));
        end
        fall = (rise + HOLDOFF > t + EDGE_LAT) ? rise + HOLDOFF : t + EDGE_LAT;
        stepTo(t + EDGE_LAT);
        checkOutput("defer_still_slow", 32'(i2cSend), 1);
        stepTo(fall - 1);
        checkOutput("defer_edge_minus1", 32'(stateO), 32'(modelState(FAST_AT, cyc - rise)));
        checkOutput("defer_i2c_held", 32'(i2cSend), 1);
        stepTo(fall);
        checkOutput("defer_fast_state", 32'(stateO), 32'(modelState(FAST_AT, cyc - rise)));
        checkOutput("defer_i2c_fall", 32'(i2cSend), 0);

        // Stall after the second edge: timeout, reset pulse, rearm.
        applyStimulus();
        t = cyc; togglePost();
        stepTo(t + EDGE_LAT);
        checkOutput("stall_slow", 32'(stateO), 2);
        stepTo(cyc + $urandom_range(200, 20));
        t = cyc; togglePost();
        hang = t + EDGE_LAT + TIMEOUT;
        stepTo(hang - 1);
        checkOutput("stall_pre_hang", 32'(stateO), 2);
        checkOutput("stall_pre_drive", 32'(cpuRstDrive), 1);
        stepTo(hang);
        checkOutput("hang_state", 32'(stateO), 5);
        checkOutput("hang_i2c", 32'(i2cSend), 0);
        checkOutput("hang_drive", 32'(cpuRstDrive), 0);
        checkOutput("hang_tries", 32'(triesO), 1);
        stepTo(hang + RSTLEN - 1);
        checkOutput("pulse_last", 32'(cpuRstDrive), 0);
        stepTo(hang + RSTLEN);
        checkOutput("pulse_released", 32'(cpuRstDrive), 1);
        stepTo(hang + RSTLEN + 1);
        checkOutput("rearmed", 32'(stateO), 1);
        checkOutput("rearmed_tries", 32'(triesO), 1);

        // Repeated CPU resets until the attempt budget runs out.
        for (int k = 2; k <= MAXTRIES; k++) begin
            lowLen = $urandom_range(6, 1);
            t = cyc; cpuRstN = 1'b0;
            if (lowLen < EDGE_LAT) begin
                stepTo(t + lowLen); cpuRstN = 1'b1;
            end
            stepTo(t + EDGE_LAT);
            checkOutput("retry_state", 32'(stateO), (k < MAXTRIES) ? 5 : 6);
            checkOutput("retry_tries", 32'(triesO), 32'(k));
            checkOutput("retry_drive", 32'(cpuRstDrive), (k < MAXTRIES) ? 0 : 1);
            stepTo(t + lowLen); cpuRstN = 1'b1;
            if (k < MAXTRIES) begin
                stepTo(t + EDGE_LAT + RSTLEN + 1);
                checkOutput("retry_rearm", 32'(stateO), 1);
            end
        end
        lowSeen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cpuRstDrive !== 1'b1) lowSeen++;
        end
        checkOutput("giveup_no_pulse", 32'(lowSeen), 0);
        checkOutput("giveup_state", 32'(stateO), 6);

        // Disable mid-boot, then reset fall coincident with an edge, then rst during the pulse.
        applyStimulus();
        t = cyc; togglePost();
        stepTo(t + EDGE_LAT);
        checkOutput("dis_slow", 32'(i2cSend), 1);
        enable = 1'b0; t = cyc;
        stepTo(t + 1);
        checkOutput("dis_state", 32'(stateO), 0);
        checkOutput("dis_i2c", 32'(i2cSend), 0);
        enable = 1'b1;
        stepTo(t + 2);
        checkOutput("reen_armed", 32'(stateO), 1);
        t = cyc; togglePost();
        stepTo(t + EDGE_LAT);
        checkOutput("reen_slow", 32'(stateO), 2);
        stepTo(cyc + 40);
        t = cyc; togglePost(); cpuRstN = 1'b0;
        stepTo(t + EDGE_LAT);
        checkOutput("coinc_state", 32'(stateO), 5);
        checkOutput("coinc_tries", 32'(triesO), 1);
        checkOutput("coinc_drive", 32'(cpuRstDrive), 0);
        cpuRstN = 1'b1; togglePost();
        stepTo(t + 10);
        rst = 1'b1; t = cyc;
        stepTo(t + 1);
        checkOutput("midrst_drive", 32'(cpuRstDrive), 1);
        checkOutput("midrst_tries", 32'(triesO), 0);
        checkOutput("midrst_state", 32'(stateO), 0);
        rst = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/post_slow_sched.md
POST_SLOW_SCHED -- requirements
Module: post_slow_sched

Interface
REQ-001 Parameter SLOW_AT, default 8'd1, number of POST edges counted before slowdown is requested.
REQ-002 Parameter FAST_AT, default 8'd4, number of POST edges counted before speedup is requested; SLOW_AT < FAST_AT required.
REQ-003 Parameter DONE_AT, default 8'd12, number of POST edges that declares boot success; FAST_AT < DONE_AT required.
REQ-004 Parameter TIMEOUT_TICKS, default 20'd400000, number of idle clk_400k cycles (1 s) without a POST edge that declares a hang.
REQ-005 Parameter RST_TICKS, default 20'd40000, number of cycles (100 ms) the CPU reset pulse is held.
REQ-006 Parameter MAX_TRIES, default 4'd15, number of attempts before the block gives up.
REQ-007 Port clk_400k, input, 1, the only clock; all logic is on its rising edge.
REQ-008 Port rst, input, 1, synchronous active-high reset.
REQ-009 Port enable, input, 1, synchronous to clk_400k; 0 forces IDLE.
REQ-010 Port post_bit, input, 1, asynchronous CPU POST bit.
REQ-011 Port cpu_rst_n, input, 1, asynchronous CPU reset observation, active low.
REQ-012 Port i2c_send, output, 1, slowdown request to the I2C injector; 1 = slow, 0 = fast.
REQ-013 Port cpu_rst_drive, output, 1, open-drain reset pulse: high-Z when idle, 1'b0 while asserted.
REQ-014 Port tries, output, 4, attempt counter.
REQ-015 Port state_o, output, 3, current state encoding, for LED/debug use.

Function
REQ-016 post_bit and cpu_rst_n shall each pass through a 2-flop synchronizer; an edge is any toggle of the synchronized post_bit, detected with 1 extra flop (3 cycles total latency).
REQ-017 States and encodings: IDLE=0, ARMED=1, SLOW=2, FAST=3, DONE=4, RSTOUT=5, FAIL=6.
REQ-018 IDLE: post_cnt and idle_cnt are cleared; on enable=1 and synchronized cpu_rst_n=1 the block goes to ARMED.
REQ-019 ARMED: each edge increments post_cnt; when post_cnt becomes SLOW_AT the block goes to SLOW and i2c_send is set to 1 on the same clock.
REQ-020 SLOW: when post_cnt becomes FAST_AT the block goes to FAST and i2c_send is set to 0.
REQ-021 FAST: when post_cnt becomes DONE_AT the block goes to DONE.
REQ-022 post_cnt is 8 bits and saturates at 255.
REQ-023 idle_cnt is 20 bits; it clears on every edge and increments otherwise while in ARMED, SLOW or FAST.
REQ-024 When idle_cnt reaches TIMEOUT_TICKS-1 in ARMED, SLOW or FAST, a hang is declared: i2c_send goes to 0 and tries increments. If the new tries value is below MAX_TRIES the block goes to RSTOUT; otherwise it goes to FAIL.
REQ-025 A synchronized cpu_rst_n falling in ARMED, SLOW or FAST is treated the same as a hang.
REQ-026 A reset fall has priority over a POST edge and over a timeout in the same cycle.
REQ-027 RSTOUT: cpu_rst_drive is driven to 0 for exactly RST_TICKS cycles. The block then releases it, clears post_cnt and idle_cnt, and waits for synchronized cpu_rst_n=1 before going to ARMED.
REQ-028 DONE and FAIL are terminal: i2c_send=0, cpu_rst_drive=high-Z, and the block leaves them only on rst or enable=0.
REQ-029 enable=0 in any state: next cycle state=IDLE, i2c_send=0, and cpu_rst_drive is released; tries is held.
REQ-030 i2c_send shall only change on state transitions and shall never toggle more than once per 256 cycles; a SLOW_AT-to-FAST_AT transition arriving earlier is deferred until 256 cycles after the slow request.
REQ-031 tries saturates at 15.

Reset
REQ-032 On rst=1 at a clock edge: state=IDLE, i2c_send=0, cpu_rst_drive=high-Z, tries=0, post_cnt=0, idle_cnt=0, all synchronizer flops=1.
REQ-033 rst asserted mid-operation (any state, including during RSTOUT) takes effect on the next edge with the same values; an in-progress reset pulse is truncated.

Verification
REQ-034 Enable=1, cpu_rst_n=1, one post toggle -> i2c_send=1 at 3 cycles after the toggle plus 1 cycle; state=2.
REQ-035 Four toggles spaced 1000 cycles -> i2c_send falls after the 4th; twelve toggles total -> state=4, tries=0.
REQ-036 Second and third toggles 50 cycles after the slow request -> i2c_send stays 1 until cycle 256 after the request (REQ-030).
REQ-037 Stop toggling after the 2nd edge -> after 400000 cycles: i2c_send=0, cpu_rst_drive=0 for 40000 cycles, tries=1, then ARMED.
REQ-038 Force hangs 15 times -> tries=15, state=6, no further reset pulses.
REQ-039 cpu_rst_n falls coincident with a post toggle in SLOW -> treated as a hang (tries+1, RSTOUT); assert rst mid-RSTOUT -> cpu_rst_drive high-Z next cycle, tries=0.
